// File: rtl/cycle_interval_monitor.sv
// Measures the cycle distance between consecutive detector events and queues the
// intervals in a small FWFT FIFO, alongside a saturating event total and a sticky drop flag.
module cycle_interval_monitor #(
  parameter int CNT_W   = 8,
  parameter int DEPTH   = 4,
  parameter int TOTAL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               detected,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   out_interval,
  output logic [TOTAL_W-1:0] total,
  output logic               overflow,
  input  logic               clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]        FULL_CNT  = (AW + 1)'(DEPTH);
  localparam logic [CNT_W-1:0]   GAP_MAX   = '1;
  localparam logic [TOTAL_W-1:0] TOTAL_MAX = '1;

  typedef enum logic {IDLE, TIMING} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   gap_q, gap_d;
  logic [CNT_W-1:0]   mem_q [DEPTH];
  logic [AW-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]        cnt_q, cnt_d;
  logic [TOTAL_W-1:0] total_q, total_d;
  logic               ovf_q, ovf_d;
  logic               push, pop, full, empty, do_write, drop;

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (detected) begin
          state_d = TIMING;
          gap_d   = CNT_W'(1);
        end
      end
      TIMING: begin
        if (detected) begin
          push  = 1'b1;
          gap_d = CNT_W'(1);
        end else if (gap_q != GAP_MAX) begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    total_d = (detected && total_q != TOTAL_MAX) ? total_q + 1'b1 : total_q;

    // A push into a full FIFO survives only if the head leaves in the same cycle.
    empty    = (cnt_q == '0);
    full     = (cnt_q == FULL_CNT);
    pop      = !empty && out_ready;
    do_write = push && (!full || pop);
    drop     = push && full && !pop;

    wr_d = do_write ? wr_q + 1'b1 : wr_q;
    rd_d = pop ? rd_q + 1'b1 : rd_q;
    case ({do_write, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    ovf_d = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      gap_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      total_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      total_q <= total_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset; the count gates what is visible.
  always_ff @(posedge clk) begin
    if (rst && do_write) mem_q[wr_q] <= gap_q;
  end

  assign out_valid    = !empty;
  assign out_interval = empty ? '0 : mem_q[rd_q];
  assign total        = total_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_cycle_interval_monitor.sv
// Randomized and directed bench for cycle_interval_monitor against a cycle-stamp
// based reference model (event timestamps, a queue of intervals, plain counters).
module tb_cycle_interval_monitor;

  localparam int CNT_W   = 8;
  localparam int DEPTH   = 4;
  localparam int TOTAL_W = 16;
  localparam int GAP_SAT = (1 << CNT_W) - 1;
  localparam int TOT_SAT = (1 << TOTAL_W) - 1;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               detected = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [CNT_W-1:0]   out_interval;
  logic [TOTAL_W-1:0] total;
  logic               overflow;
  logic               clr_ovf = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int unsigned cyc = 0;
  int unsigned lastEvt = 0;
  bit          seenEvt = 0;
  int          mq[$];
  int          mTotal = 0;
  bit          mOvf = 0;
  int          dutPops[$];

  cycle_interval_monitor #(.CNT_W(CNT_W), .DEPTH(DEPTH), .TOTAL_W(TOTAL_W)) dut (
    .clk(clk), .rst(rst), .detected(detected), .out_valid(out_valid),
    .out_ready(out_ready), .out_interval(out_interval), .total(total),
    .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  // One clock: drive at negedge, advance model at the edge, return at next negedge.
  task automatic cycle(input bit det, input bit rdy, input bit clr, input bit rstn);
    bit popNow;
    int iv;
    detected  = det;
    out_ready = rdy;
    clr_ovf   = clr;
    rst       = rstn;
    if (rstn && out_valid === 1'b1 && rdy) dutPops.push_back(int'(out_interval));
    @(posedge clk);
    cyc++;
    if (!rstn) begin
      mq.delete();
      mTotal  = 0;
      mOvf    = 0;
      seenEvt = 0;
    end else begin
      popNow = (mq.size() != 0) && rdy;
      if (popNow) void'(mq.pop_front());
      if (clr) mOvf = 0;
      if (det) begin
        if (mTotal < TOT_SAT) mTotal++;
        if (seenEvt) begin
          iv = int'(cyc - lastEvt);
          if (iv > GAP_SAT) iv = GAP_SAT;
          if (mq.size() < DEPTH) mq.push_back(iv);
          else mOvf = 1;
        end
        seenEvt = 1;
        lastEvt = cyc;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(0, 1, 0, 1);
  endtask

  task automatic doReset();
    cycle(0, 0, 0, 0);
    cycle(1, 1, 1, 0);
    cycle(0, 0, 0, 1);
  endtask

  task automatic test_reset();
    doReset();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b expected 0", out_valid); end
    checks++;
    if (total !== '0) begin errors++; $display("FAIL reset_total got %0d expected 0", total); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b expected 0", overflow); end
    checks++;
    if (out_interval !== '0) begin errors++; $display("FAIL reset_interval got %0d expected 0", out_interval); end
    // Queue data, then reset mid-stream: everything must vanish.
    for (int i = 0; i < 6; i++) cycle(i % 2 == 0, 0, 0, 1);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL prefill_valid got %0b expected 1", out_valid); end
    doReset();
    checks++;
    if (out_valid !== 1'b0 || total !== '0) begin
      errors++; $display("FAIL midreset got valid=%0b total=%0d expected 0/0", out_valid, total);
    end
  endtask

  task automatic test_basic();
    doReset();
    dutPops.delete();
    for (int i = 0; i < 22; i++) cycle(i == 10 || i == 13 || i == 15, 1, 0, 1);
    checks++;
    if (dutPops.size() !== 2) begin
      errors++; $display("FAIL basic_popcount got %0d expected 2", dutPops.size());
    end else begin
      checks++;
      if (dutPops[0] !== 3 || dutPops[1] !== 2) begin
        errors++; $display("FAIL basic_values got %0d,%0d expected 3,2", dutPops[0], dutPops[1]);
      end
    end
    checks++;
    if (total !== 16'd3) begin errors++; $display("FAIL basic_total got %0d expected 3", total); end
  endtask

  task automatic test_hold();
    doReset();
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 1);
    cycle(0, 0, 0, 1);
    checks++;
    if (total !== 16'd4) begin errors++; $display("FAIL hold_total got %0d expected 4", total); end
    checks++;
    if (out_valid !== 1'b1 || out_interval !== 8'd1) begin
      errors++; $display("FAIL hold_head got valid=%0b val=%0d expected 1/1", out_valid, out_interval);
    end
    dutPops.delete();
    drain(6);
    checks++;
    if (dutPops.size() !== 3 || dutPops[0] !== 1 || dutPops[1] !== 1 || dutPops[2] !== 1) begin
      errors++; $display("FAIL hold_drain got %0d samples expected three 1s", dutPops.size());
    end
  endtask

  task automatic test_overflow();
    doReset();
    for (int i = 0; i < 12; i++) cycle(i % 2 == 0 && i <= 10, 0, 0, 1);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %0b expected 1", overflow); end
    cycle(0, 0, 1, 1);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %0b expected 0", overflow); end
    dutPops.delete();
    drain(8);
    checks++;
    if (dutPops.size() !== 4) begin
      errors++; $display("FAIL ovf_drain_count got %0d expected 4", dutPops.size());
    end else begin
      foreach (dutPops[k]) begin
        checks++;
        if (dutPops[k] !== 2) begin errors++; $display("FAIL ovf_drain_val got %0d expected 2", dutPops[k]); end
      end
    end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %0b expected 0", out_valid); end
  endtask

  task automatic test_saturate();
    doReset();
    for (int i = 0; i <= 300; i++) cycle(i == 0 || i == 300, 0, 0, 1);
    checks++;
    if (out_valid !== 1'b1 || out_interval !== 8'd255) begin
      errors++; $display("FAIL sat_head got valid=%0b val=%0d expected 1/255", out_valid, out_interval);
    end
    dutPops.delete();
    drain(3);
    checks++;
    if (dutPops.size() !== 1) begin errors++; $display("FAIL sat_count got %0d expected 1", dutPops.size()); end
  endtask

  task automatic test_back_to_back();
    doReset();
    for (int i = 0; i < 11; i++) cycle(i % 2 == 0 && i <= 8, 0, 0, 1);
    cycle(1, 1, 0, 1);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_ovf got %0b expected 0", overflow); end
    dutPops.delete();
    drain(8);
    checks++;
    if (dutPops.size() !== 4) begin
      errors++; $display("FAIL fullpop_count got %0d expected 4", dutPops.size());
    end else begin
      checks++;
      if (dutPops[0] !== 2 || dutPops[1] !== 2 || dutPops[2] !== 2 || dutPops[3] !== 3) begin
        errors++; $display("FAIL fullpop_order got %0d,%0d,%0d,%0d expected 2,2,2,3",
                           dutPops[0], dutPops[1], dutPops[2], dutPops[3]);
      end
    end
  endtask

  task automatic test_random();
    int density;
    int expHead;
    doReset();
    for (int blk = 0; blk < 12; blk++) begin
      case ($urandom_range(0, 3))
        0:       density = 1;
        1:       density = 20;
        2:       density = 60;
        default: density = 95;
      endcase
      for (int i = 0; i < 200; i++) begin
        cycle($urandom_range(0, 99) < density, $urandom_range(0, 1) == 1,
              $urandom_range(0, 19) == 0, $urandom_range(0, 299) != 0);
        expHead = (mq.size() != 0) ? mq[0] : 0;
        checks++;
        if (out_valid !== (mq.size() != 0)) begin
          errors++; $display("FAIL rnd_valid cyc %0d got %0b expected %0b", cyc, out_valid, mq.size() != 0);
        end
        checks++;
        if (int'(out_interval) !== expHead) begin
          errors++; $display("FAIL rnd_head cyc %0d got %0d expected %0d", cyc, out_interval, expHead);
        end
        checks++;
        if (int'(total) !== mTotal) begin
          errors++; $display("FAIL rnd_total cyc %0d got %0d expected %0d", cyc, total, mTotal);
        end
        checks++;
        if (overflow !== mOvf) begin
          errors++; $display("FAIL rnd_ovf cyc %0d got %0b expected %0b", cyc, overflow, mOvf);
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_hold();
    test_overflow();
    test_saturate();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
